// File: rtl/caesar_sram_streamer.sv
// Moves command-sized blocks of words between one Caesar SRAM bank port and a pair of
// valid/ready streams. A 2-entry read buffer with bypass absorbs backpressure on the read side.
module caesar_sram_streamer #(
  parameter  int NUM_WORDS = 1024,
  parameter  int LEN_WIDTH = 16,
  localparam int AddrWidth = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_write_i,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0] cmd_len_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [31:0]          s_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [31:0]          m_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 sleep_i,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [31:0]          wdata_o,
  output logic [3:0]           be_o,
  output logic                 set_retentive_no,
  input  logic [31:0]          rdata_i
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d, addrNext;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic                 inflight_q, inflight_d;
  logic [31:0]          fifoMem_q [2];
  logic                 rdPtr_q, wrPtr_q;
  logic [1:0]           occ_q;
  logic                 fifoEmpty, mPop, fifoPush, fifoPop, readWindowOpen;

  // Explicit wrap compare so non-power-of-two banks also wrap to 0.
  assign addrNext = (addr_q == AddrWidth'(NUM_WORDS - 1)) ? '0 : addr_q + AddrWidth'(1);

  assign fifoEmpty      = (occ_q == 2'd0);
  assign readWindowOpen = (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2);
  assign mPop           = m_valid_o && m_ready_i;
  // Returning read data bypasses the buffer when it is empty and the sink takes it now.
  assign fifoPush       = inflight_q && !(fifoEmpty && mPop);
  assign fifoPop        = mPop && !fifoEmpty;
  assign m_data_o       = fifoEmpty ? rdata_i : fifoMem_q[rdPtr_q];

  assign addr_o           = addr_q;
  assign wdata_o          = s_data_i;
  assign be_o             = 4'hF;
  assign busy_o           = (state_q != IDLE);
  assign set_retentive_no = ~(sleep_i && (state_q == IDLE));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    inflight_d  = 1'b0;
    cmd_ready_o = 1'b0;
    s_ready_o   = 1'b0;
    m_valid_o   = 1'b0;
    req_o       = 1'b0;
    we_o        = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          count_d = cmd_len_i;
          if (cmd_len_i == '0)   state_d = DONE;
          else if (cmd_write_i)  state_d = WRITE;
          else                   state_d = READ;
        end
      end
      WRITE: begin
        s_ready_o = 1'b1;
        req_o     = s_valid_i;
        we_o      = s_valid_i;
        if (s_valid_i) begin
          addr_d  = addrNext;
          count_d = count_q - LEN_WIDTH'(1);
          if (count_q == LEN_WIDTH'(1)) state_d = DONE;
        end
      end
      READ: begin
        m_valid_o = !fifoEmpty || inflight_q;
        if ((count_q != '0) && readWindowOpen) begin
          req_o      = 1'b1;
          addr_d     = addrNext;
          count_d    = count_q - LEN_WIDTH'(1);
          inflight_d = 1'b1;
        end
        if ((count_q == '0) && !inflight_q && fifoEmpty) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      rdPtr_q    <= 1'b0;
      wrPtr_q    <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      if (fifoPush) wrPtr_q <= ~wrPtr_q;
      if (fifoPop)  rdPtr_q <= ~rdPtr_q;
      case ({fifoPush, fifoPop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifoPush) fifoMem_q[wrPtr_q] <= rdata_i;
  end

endmodule
